// File: rtl/seq_restoring_divider_if.sv
// +--------------------------------------------------------------------+
// | seq_restoring_divider_if                                           |
// | Start/operand request and result bundle for seq_restoring_divider. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface seq_restoring_divider_if #(
  parameter int SIZE = 8
);

  // Request side: a start strobe carrying the two operands.
  logic            iStart;
  logic [SIZE-1:0] iDividend;
  logic [SIZE-1:0] iDivisor;

  // Result side: registered quotient/remainder plus status.
  logic [SIZE-1:0] oQuotient;
  logic [SIZE-1:0] oRemainder;
  logic            oBusy;
  logic            oDone;
  logic            oDivByZero;

  // Master issues divisions and consumes results.
  modport master (
    output iStart,
    output iDividend,
    output iDivisor,
    input  oQuotient,
    input  oRemainder,
    input  oBusy,
    input  oDone,
    input  oDivByZero
  );

  // Slave is the divider itself.
  modport slave (
    input  iStart,
    input  iDividend,
    input  iDivisor,
    output oQuotient,
    output oRemainder,
    output oBusy,
    output oDone,
    output oDivByZero
  );

endinterface

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// +--------------------------------------------------------------------+
// | seq_restoring_divider                                              |
// | Multi-cycle restoring shift-subtract divider, one quotient bit per |
// | clock. DIV/MOD unit for the MiniAlu datapath.                      |
// | Optional feature macro: SIGNED_DIV_EN (two's complement operands,  |
// | truncating division; sign fix-up folded into the DONE transition). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_restoring_divider #(
  parameter int SIZE = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  seq_restoring_divider_if.slave       bus
);

  // Iteration counter runs 0..SIZE-1; SIZE >= 2 keeps this at least 1 bit.
  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;

  // r_dvd starts as the dividend magnitude; each iteration shifts its MSB
  // out into the partial remainder and shifts the new quotient bit in at
  // the LSB, so after SIZE iterations it holds the quotient.
  logic [SIZE-1:0] r_dvd;
  logic [SIZE-1:0] r_dvs;
  logic [SIZE-1:0] r_rem;

  // Registered outputs.
  logic [SIZE-1:0] r_quotient;
  logic [SIZE-1:0] r_remainder;
  logic            r_busy;
  logic            r_done;
  logic            r_dbz;

  // Operand magnitudes presented to the unsigned core at start time.
  logic [SIZE-1:0] w_a_mag;
  logic [SIZE-1:0] w_b_mag;

  // One restoring step.
  logic [SIZE:0]   w_trial;
  logic [SIZE:0]   w_diff;
  logic            w_ge;
  logic [SIZE-1:0] w_rem_next;
  logic [SIZE-1:0] w_quo_next;
  logic            w_last;

  // Final results after optional sign fix-up.
  logic [SIZE-1:0] w_q_final;
  logic [SIZE-1:0] w_r_final;

`ifdef SIGNED_DIV_EN
  // Result signs are captured with the operands so the fix-up can be
  // applied on the same edge that writes the outputs.
  logic            r_qneg;
  logic            r_rneg;
  logic            w_a_neg;
  logic            w_b_neg;

  assign w_a_neg = bus.iDividend[SIZE-1];
  assign w_b_neg = bus.iDivisor[SIZE-1];

  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed here.
  assign w_a_mag = w_a_neg ? (~bus.iDividend + SIZE'(1)) : bus.iDividend;
  assign w_b_mag = w_b_neg ? (~bus.iDivisor  + SIZE'(1)) : bus.iDivisor;

  // Most-negative / -1 yields magnitude 2^(SIZE-1) with a positive sign,
  // which wraps to the most-negative pattern as required.
  assign w_q_final = r_qneg ? (~w_quo_next + SIZE'(1)) : w_quo_next;
  assign w_r_final = r_rneg ? (~w_rem_next + SIZE'(1)) : w_rem_next;
`else
  assign w_a_mag   = bus.iDividend;
  assign w_b_mag   = bus.iDivisor;
  assign w_q_final = w_quo_next;
  assign w_r_final = w_rem_next;
`endif

  // Bring down the next dividend bit beside the partial remainder. The
  // remainder is always below the divisor, so SIZE+1 bits never overflow.
  assign w_trial    = {r_rem, r_dvd[SIZE-1]};
  assign w_diff     = w_trial - {1'b0, r_dvs};

  // trial < 2*divisor, so a non-negative difference always has its top bit
  // clear, and a borrow always sets it: the top bit is the compare result.
  assign w_ge       = ~w_diff[SIZE];
  assign w_rem_next = w_ge ? w_diff[SIZE-1:0] : w_trial[SIZE-1:0];
  assign w_quo_next = {r_dvd[SIZE-2:0], w_ge};
  assign w_last     = (r_count == CW'(SIZE - 1));

  // Control FSM with registered outputs; reset aborts any division.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.iStart) begin
            if (bus.iDivisor == '0) begin
              // Divide-by-zero skips the core entirely.
              r_quotient  <= '1;
              r_remainder <= bus.iDividend;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_dvd   <= w_a_mag;
              r_dvs   <= w_b_mag;
              r_rem   <= '0;
              r_count <= '0;
              r_dbz   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= RUN;
`ifdef SIGNED_DIV_EN
              r_qneg  <= w_a_neg ^ w_b_neg;
              r_rneg  <= w_a_neg;
`endif
            end
          end
        end

        RUN: begin
          r_dvd   <= w_quo_next;
          r_rem   <= w_rem_next;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            // Outputs only change here, so they hold steady through RUN.
            r_quotient  <= w_q_final;
            r_remainder <= w_r_final;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end

        DONE: begin
          // Any iStart seen here is dropped, not queued.
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.oQuotient  = r_quotient;
  assign bus.oRemainder = r_remainder;
  assign bus.oBusy      = r_busy;
  assign bus.oDone      = r_done;
  assign bus.oDivByZero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none

module tb_seq_restoring_divider;

  localparam int SIZE = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  seq_restoring_divider_if #(.SIZE(SIZE)) bus ();

  seq_restoring_divider #(.SIZE(SIZE)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, want, $time);
    end
  endtask

  // Reference arithmetic: plain integer division on the operand values.
  function automatic void ref_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                  output logic [SIZE-1:0] q, output logic [SIZE-1:0] r);
`ifdef SIGNED_DIV_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = SIZE'(sa / sb);
    r  = SIZE'(sa % sb);
`else
    q = a / b;
    r = a % b;
`endif
  endfunction

  // Behavioural model: a start accepted while idle delivers its result
  // SIZE+1 cycles later (1 cycle for a zero divisor); one idle cycle after
  // each result before the next start can be taken.
  logic [SIZE-1:0] m_q, m_r, m_pq, m_pr;
  logic            m_busy, m_done, m_dbz;
  int              m_left;
  bit              m_prev_done;

  initial begin
    m_q = '0; m_r = '0; m_pq = '0; m_pr = '0;
    m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
  end

  always @(posedge Clock) begin
    if (Reset) begin
      m_q = '0; m_r = '0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
    end else begin
      m_prev_done = m_done;
      m_done      = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_q = m_pq; m_r = m_pr; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (!m_prev_done && bus.iStart === 1'b1) begin
        if (bus.iDivisor == '0) begin
          m_q = '1; m_r = bus.iDividend; m_dbz = 1'b1; m_done = 1'b1;
        end else begin
          ref_div(bus.iDividend, bus.iDivisor, m_pq, m_pr);
          m_dbz = 1'b0; m_busy = 1'b1; m_left = SIZE;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(negedge Clock) begin
    if (chk_on) begin
      chk("cyc quotient",  32'(bus.oQuotient),  32'(m_q));
      chk("cyc remainder", 32'(bus.oRemainder), 32'(m_r));
      chk("cyc busy",      32'(bus.oBusy),      32'(m_busy));
      chk("cyc done",      32'(bus.oDone),      32'(m_done));
      chk("cyc divbyzero", 32'(bus.oDivByZero), 32'(m_dbz));
    end
  end

  // Directed operation with literal expectations; optional stray start
  // pulse (g_at > 0) injected at that cycle of the operation.
  task automatic run_op(input string tag, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [SIZE-1:0] eq, input logic [SIZE-1:0] er, input bit edbz,
                        input int elat, input int ebusy,
                        input int g_at, input logic [SIZE-1:0] ga, input logic [SIZE-1:0] gb);
    int lat, busy;
    @(negedge Clock);
    bus.iStart = 1'b1; bus.iDividend = a; bus.iDivisor = b;
    @(negedge Clock);
    bus.iStart = 1'b0;
    lat = 1; busy = 0;
    while (bus.oDone !== 1'b1 && lat <= SIZE + 4) begin
      if (bus.oBusy === 1'b1) busy++;
      if (lat == g_at) begin
        bus.iStart = 1'b1; bus.iDividend = ga; bus.iDivisor = gb;
      end else begin
        bus.iStart = 1'b0;
      end
      @(negedge Clock);
      lat++;
    end
    bus.iStart = 1'b0;
    chk({tag, " done seen"}, 32'(bus.oDone),      32'd1);
    chk({tag, " latency"},   32'(lat),            32'(elat));
    chk({tag, " busy cyc"},  32'(busy),           32'(ebusy));
    chk({tag, " quotient"},  32'(bus.oQuotient),  32'(eq));
    chk({tag, " remainder"}, 32'(bus.oRemainder), 32'(er));
    chk({tag, " divbyzero"}, 32'(bus.oDivByZero), 32'(edbz));
  endtask

  initial begin
    bus.iStart = 1'b0; bus.iDividend = '0; bus.iDivisor = '0;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst quotient",  32'(bus.oQuotient),  32'd0);
    chk("rst remainder", 32'(bus.oRemainder), 32'd0);
    chk("rst busy",      32'(bus.oBusy),      32'd0);
    chk("rst done",      32'(bus.oDone),      32'd0);
    chk("rst divbyzero", 32'(bus.oDivByZero), 32'd0);
    chk_on = 1'b1;
    Reset  = 1'b0;

`ifdef SIGNED_DIV_EN
    run_op("neg100/7",  8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, SIZE + 1, SIZE, 0, '0, '0);
    run_op("neg128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, SIZE + 1, SIZE, 0, '0, '0);
`else
    run_op("200/7", 8'd200, 8'd7, 8'd28,  8'd4, 1'b0, SIZE + 1, SIZE, 0, '0, '0);
    run_op("5/9",   8'd5,   8'd9, 8'd0,   8'd5, 1'b0, SIZE + 1, SIZE, 0, '0, '0);
    run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, SIZE + 1, SIZE, 0, '0, '0);
`endif
    run_op("37/0",  8'd37,  8'd0, 8'd255, 8'd37, 1'b1, 1, 0, 0, '0, '0);
    run_op("100/3 stray", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0, SIZE + 1, SIZE, 4, 8'd10, 8'd2);

    // Reset in the third RUN cycle aborts with cleared outputs.
    @(negedge Clock);
`ifdef SIGNED_DIV_EN
    bus.iStart = 1'b1; bus.iDividend = 8'd100; bus.iDivisor = 8'd3;
`else
    bus.iStart = 1'b1; bus.iDividend = 8'd250; bus.iDivisor = 8'd6;
`endif
    @(negedge Clock);
    bus.iStart = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort quotient",  32'(bus.oQuotient),  32'd0);
    chk("abort remainder", 32'(bus.oRemainder), 32'd0);
    chk("abort busy",      32'(bus.oBusy),      32'd0);
    chk("abort done",      32'(bus.oDone),      32'd0);
    chk("abort divbyzero", 32'(bus.oDivByZero), 32'd0);
`ifdef SIGNED_DIV_EN
    run_op("100/3 after rst", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0, SIZE + 1, SIZE, 0, '0, '0);
`else
    run_op("250/6 after rst", 8'd250, 8'd6, 8'd41, 8'd4, 1'b0, SIZE + 1, SIZE, 0, '0, '0);
`endif

    // Random traffic: starts at any time, some zero divisors, rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clock);
      bus.iStart    = ($urandom_range(0, 3) == 0);
      bus.iDividend = SIZE'($urandom);
      bus.iDivisor  = ($urandom_range(0, 7) == 0) ? '0 : SIZE'($urandom);
      Reset         = ($urandom_range(0, 149) == 0);
    end
    @(negedge Clock);
    Reset = 1'b0; bus.iStart = 1'b0;
    repeat (SIZE + 4) @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
